// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-serial data-memory responder:
// RV32 funct3 load/store modes, FSM encoding and access-size helpers.
package dmem_pkg;

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_W  = 3'b010;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DRAIN,
        ST_DONE
    } dmem_state_t;

    function automatic logic [2:0] size_of(input logic [2:0] mode);
        case (mode)
            MODE_B, MODE_BU: size_of = 3'd1;
            MODE_H, MODE_HU: size_of = 3'd2;
            default:         size_of = 3'd4;
        endcase
    endfunction

    // Legal mode with natural alignment; anything else is answered with err.
    function automatic logic access_ok(input logic [2:0] mode, input logic [1:0] adr_lo);
        case (mode)
            MODE_B, MODE_BU: access_ok = 1'b1;
            MODE_H, MODE_HU: access_ok = ~adr_lo[0];
            MODE_W:          access_ok = (adr_lo == 2'b00);
            default:         access_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_responder_load_extend.sv
// Sign/zero extension of a raw little-endian load word according to the
// RV32 load mode; also used by the existing dmem load path.
module load_extend
    import dmem_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        case (mode)
            MODE_B:  ext = {{24{raw[7]}}, raw[7:0]};
            MODE_H:  ext = {{16{raw[15]}}, raw[15:0]};
            MODE_BU: ext = {24'd0, raw[7:0]};
            MODE_HU: ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/dmem_byte_responder.sv
// M-stage data-memory responder: serialises B/H/W loads and stores over a
// byte-wide synchronous SRAM port and stalls the pipeline while doing so.
module dmem_byte_responder
    import dmem_pkg::*;
#(
    parameter int MEM_AW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        mode,
    input  logic [31:0]       addr,
    input  logic [31:0]       wd,
    output logic [31:0]       rd,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    dmem_state_t state;
    logic        we_q;
    logic [2:0]  mode_q;
    logic [31:0] wd_q;
    logic [1:0]  cnt;
    logic [1:0]  cnt_nxt;
    logic        last;
    logic [31:0] asm_q;
    logic [31:0] asm_nxt;
    logic [31:0] ext_w;
    // Read data returns one cycle after the strobe: remember which byte it is.
    logic        cap_vld;
    logic [1:0]  cap_idx;
    logic        addr_unused;

    assign addr_unused = ^addr[31:MEM_AW];
    assign cnt_nxt     = cnt + 2'd1;
    assign last        = ({1'b0, cnt} == (size_of(mode_q) - 3'd1));

    // The pipeline must stall in the very cycle the request appears.
    assign busy = reset & ((state == ST_IDLE) ? req : (state != ST_DONE));

    always_comb begin
        asm_nxt = asm_q;
        if (cap_vld)
            asm_nxt[{cap_idx, 3'b000} +: 8] = mem_rdata;
    end

    load_extend u_ext (
        .mode (mode_q),
        .raw  (asm_nxt),
        .ext  (ext_w)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            mode_q    <= MODE_B;
            wd_q      <= '0;
            cnt       <= '0;
            asm_q     <= '0;
            cap_vld   <= 1'b0;
            cap_idx   <= '0;
            rd        <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            cap_vld <= mem_re;
            cap_idx <= cnt;
            if (cap_vld)
                asm_q <= asm_nxt;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        we_q   <= we;
                        mode_q <= mode;
                        wd_q   <= wd;
                        cnt    <= '0;
                        if (!access_ok(mode, addr[1:0])) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= ST_ACCESS;
                            mem_addr  <= addr[MEM_AW-1:0];
                            mem_we    <= we;
                            mem_re    <= ~we;
                            mem_wdata <= wd[7:0];
                        end
                    end
                end
                ST_ACCESS: begin
                    if (last) begin
                        mem_we <= 1'b0;
                        mem_re <= 1'b0;
                        if (we_q) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else begin
                        cnt       <= cnt_nxt;
                        mem_addr  <= mem_addr + MEM_AW'(1);
                        mem_wdata <= wd_q[{cnt_nxt, 3'b000} +: 8];
                    end
                end
                ST_DRAIN: begin
                    rd    <= ext_w;
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_byte_responder.sv
// Scoreboard bench for dmem_byte_responder: the driver queues expected
// responses and SRAM strobes, a negedge monitor pops and compares them.
module tb_dmem_byte_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  mode = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        busy, done, err;
    logic [15:0] mem_addr;
    logic        mem_we, mem_re;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    logic [7:0]  mem [0:65535];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct { int issue; int lat; logic err; logic [31:0] rd; } rsp_t;
    typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
    rsp_t        rsp_q[$];
    wr_t         wr_q[$];
    logic [15:0] rdq[$];

    dmem_byte_responder #(.MEM_AW(16)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .mode(mode),
        .addr(addr), .wd(wd), .rd(rd), .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte-wide synchronous SRAM
    initial for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (reset) begin
            if (done) begin
                if (rsp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("done_latency", 32'(cyc - r.issue), 32'(r.lat));
                    chk("err", {31'd0, err}, {31'd0, r.err});
                    chk("rd", rd, r.rd);
                end
            end
            if (mem_we) begin
                if (wr_q.size() == 0) chk("unexpected_mem_we", {16'd0, mem_addr}, 32'hFFFFFFFF);
                else begin
                    wr_t x;
                    x = wr_q.pop_front();
                    chk("wr_addr", {16'd0, mem_addr}, {16'd0, x.a});
                    chk("wr_data", {24'd0, mem_wdata}, {24'd0, x.d});
                end
            end
            if (mem_re) begin
                if (rdq.size() == 0) chk("unexpected_mem_re", {16'd0, mem_addr}, 32'hFFFFFFFF);
                else chk("rd_addr", {16'd0, mem_addr}, {16'd0, rdq.pop_front()});
            end
        end
    end

    // lat: cycles from T0 to done; a store moves lat-1 bytes, a load lat-2.
    task automatic issue(input logic w, input logic [2:0] m, input logic [31:0] a,
                         input logic [31:0] d, input int lat, input logic e,
                         input logic [31:0] erd, input bit hold);
        rsp_t r;
        wr_t  x;
        bit   seen;
        @(negedge clk);
        req = 1'b1; we = w; mode = m; addr = a; wd = d;
        if (!e) begin
            for (int i = 0; i < (w ? lat - 1 : lat - 2); i++) begin
                logic [15:0] ba;
                ba = a[15:0] + 16'(i);
                if (w) begin
                    x.a = ba; x.d = d[8*i +: 8];
                    wr_q.push_back(x);
                end else rdq.push_back(ba);
            end
        end
        r.issue = cyc; r.lat = lat; r.err = e; r.rd = erd;
        rsp_q.push_back(r);
        #1 chk("busy_t0", {31'd0, busy}, 32'd1);
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk); #1;
            if (done) seen = 1'b1;
            else chk("busy_access", {31'd0, busy}, 32'd1);
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        else chk("busy_done", {31'd0, busy}, 32'd0);
        if (!hold) req = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rd", rd, 32'd0);
        chk("rst_flags", {28'd0, busy, done, err, mem_we}, 32'd0);
        chk("rst_mem", {7'd0, mem_re, mem_wdata, mem_addr}, 32'd0);
        reset = 1'b1;

        //     we    mode    addr          wd            lat err rd_exp        hold
        issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 5, 1'b0, 32'h0000_0000, 0); // SW
        issue(1'b1, 3'b000, 32'h0000_0020, 32'h0000_0080, 2, 1'b0, 32'h0000_0000, 0); // SB
        issue(1'b0, 3'b000, 32'h0000_0020, 32'h0,         3, 1'b0, 32'hFFFFFF80, 0); // LB
        issue(1'b0, 3'b100, 32'h0000_0020, 32'h0,         3, 1'b0, 32'h00000080, 0); // LBU
        issue(1'b1, 3'b001, 32'h0000_0040, 32'h0000_1234, 3, 1'b0, 32'h00000080, 0); // SH
        issue(1'b0, 3'b101, 32'h0000_0040, 32'h0,         4, 1'b0, 32'h00001234, 0); // LHU
        issue(1'b0, 3'b001, 32'h0000_0100, 32'h0,         4, 1'b0, 32'hFFFFBEEF, 0); // LH
        issue(1'b0, 3'b001, 32'h0000_0101, 32'h0,         1, 1'b1, 32'hFFFFBEEF, 0); // LH odd
        issue(1'b0, 3'b011, 32'h0000_0100, 32'h0,         1, 1'b1, 32'hFFFFBEEF, 0); // illegal
        issue(1'b1, 3'b010, 32'h0000_0102, 32'h55555555,  1, 1'b1, 32'hFFFFBEEF, 0); // SW misal
        issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEADBEEF,  5, 1'b0, 32'hFFFFBEEF, 1); // req held
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0,         6, 1'b0, 32'hDEADBEEF, 0); // LW
        issue(1'b1, 3'b000, 32'h0001_FFFF, 32'h0000_00A5, 2, 1'b0, 32'hDEADBEEF, 0); // SB wrap
        issue(1'b1, 3'b001, 32'h0000_FFFE, 32'h0000_C3B4, 3, 1'b0, 32'hDEADBEEF, 0); // SH top
        issue(1'b0, 3'b001, 32'h0001_FFFE, 32'h0,         4, 1'b0, 32'hFFFFC3B4, 0); // LH wrap
        issue(1'b0, 3'b010, 32'h0000_FFFC, 32'h0,         6, 1'b0, 32'hC3B40000, 0); // LW top
        chk("mem_ffff", {24'd0, mem[16'hFFFF]}, 32'h0000_00C3);

        // Reset in the middle of a word store, after the second byte lands.
        @(negedge clk);
        req = 1'b1; we = 1'b1; mode = 3'b010; addr = 32'h200; wd = 32'h11223344;
        wr_q.push_back('{a: 16'h0200, d: 8'h44});
        wr_q.push_back('{a: 16'h0201, d: 8'h33});
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_strobes", {30'd0, mem_we, mem_re}, 32'd0);
        chk("arst_busy_done", {29'd0, busy, done, err}, 32'd0);
        chk("arst_rd", rd, 32'd0);
        chk("arst_mem_addr", {16'd0, mem_addr}, 32'd0);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("arst_mem200", {mem[16'h0200], mem[16'h0201], mem[16'h0202], 8'h00}, 32'h4433_0000);
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0, 6, 1'b0, 32'hDEADBEEF, 0); // LW after reset

        repeat (4) @(negedge clk);
        chk("queues_empty", 32'(rsp_q.size() + wr_q.size() + rdq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
